// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: drives a multiplexed three-digit, common-anode seven-segment
// display from a packed BCD value.
//
// A prescaler divides clk into digit periods of SCAN_DIV cycles. A digit FSM
// (DIG0 ones -> DIG1 tens -> DIG2 hundreds) steps once per period. The first
// GUARD cycles of each period keep every anode off so that the previous
// digit's cathodes do not ghost onto the next digit.
//
// A new value is loaded into a pending register. It reaches the display
// register only at a frame boundary, so one frame never mixes two values.
//
// Ports:
//   clk    - sole clock, rising edge
//   reset  - synchronous, active-high reset
//   bcd    - [9:8] hundreds, [7:4] tens, [3:0] ones
//   load   - one-cycle strobe that samples bcd
//   blank  - level; 1 turns every anode off
//   an     - active-low anodes: [0] ones, [1] tens, [2] hundreds, [3] unused (1)
//   seg    - active-low cathodes {g,f,e,d,c,b,a}, registered
//   dp     - active-low decimal point, always off (1)
//
// Build option: define SEG_LEADING_ZERO_BLANK_EN to suppress leading zeros
// on the hundreds and tens digits. Anode timing does not change.
module bcd_seg_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int GUARD    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] bcd,
  input  logic       load,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [6:0]    SEG_OFF   = 7'b1111111;

  typedef enum logic [1:0] {DIG0 = 2'd0, DIG1 = 2'd1, DIG2 = 2'd2} dig_e;

  logic [CW-1:0] cnt_q, cnt_d;
  dig_e          dig_q, dig_d;
  logic [9:0]    pend_q, pend_d;
  logic [9:0]    disp_q, disp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic       tick, frame, lz_blank;
  logic [3:0] nib;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b0111111;  // non-BCD nibble shows a dash
    endcase
  endfunction

  // Prescaler, digit FSM and value registers.
  always_comb begin
    tick   = (cnt_q == CNT_LAST);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    dig_d  = dig_q;
    if (tick) begin
      case (dig_q)
        DIG0:    dig_d = DIG1;
        DIG1:    dig_d = DIG2;
        default: dig_d = DIG0;
      endcase
    end
    frame  = tick && (dig_q == DIG2);
    pend_d = load ? bcd : pend_q;
    // A load on the boundary cycle goes straight to the display.
    disp_d = disp_q;
    if (frame) disp_d = load ? bcd : pend_q;
  end

  // Output decode. These values are registered, so the pins show the
  // state as it was before the edge.
  always_comb begin
    case (dig_q)
      DIG0:    nib = disp_q[3:0];
      DIG1:    nib = disp_q[7:4];
      default: nib = {2'b00, disp_q[9:8]};
    endcase

    lz_blank = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    case (dig_q)
      DIG2:    lz_blank = (disp_q[9:8] == 2'd0);
      DIG1:    lz_blank = (disp_q[9:8] == 2'd0) && (disp_q[7:4] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
`endif

    // blank only gates the anodes. seg keeps following the digit.
    seg_d = lz_blank ? SEG_OFF : dec7(nib);

    an_d = 4'b1111;
    if (cnt_q >= CNT_GUARD && !blank) begin
      case (dig_q)
        DIG0:    an_d[0] = 1'b0;
        DIG1:    an_d[1] = 1'b0;
        default: an_d[2] = 1'b0;
      endcase
    end
  end

  // Reset takes priority, so a load in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      dig_q  <= DIG0;
      pend_q <= '0;
      disp_q <= '0;
      an_q   <= 4'b1111;
      seg_q  <= SEG_OFF;
    end else begin
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule
